// File: rtl/pong_pkg.sv
// Shared definitions for the pong button path: button indices, debounce default, FSM encoding.
package pong_pkg;

  localparam int BTN_UP_P1   = 0;
  localparam int BTN_DOWN_P1 = 1;
  localparam int BTN_UP_P2   = 2;
  localparam int BTN_DOWN_P2 = 3;

  // 10 ms at 25.175 MHz
  localparam int DB_CYCLES_DEFAULT = 251_750;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-flop synchroniser, debounce FSM and stability counter; level and pulses registered.
// press_nxt exposes next-cycle press so the top can register any_press alongside the pulse.
module debounce_channel
  import pong_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic clk_0,
  input  logic rst,
  input  logic btn_n_raw,
  output logic level_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_nxt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            sync0_q, sync0_d;
  logic            sync1_q, sync1_d;
  db_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            s;

  assign s = sync1_q;

  always_comb begin
    sync0_d   = btn_n_raw;
    sync1_d   = sync0_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        level_d = 1'b1;
        if (!s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (s) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          level_d = 1'b0;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        level_d = 1'b0;
        if (s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_RELEASED;
          level_d   = 1'b1;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        level_d = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      sync0_q   <= 1'b1;
      sync1_q   <= 1'b1;
      state_q   <= ST_RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync0_q   <= sync0_d;
      sync1_q   <= sync1_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_n       = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_nxt     = press_d;

endmodule

// File: rtl/button_conditioner.sv
// Four independent debounce channels for the raw active-low player buttons.
// All outputs registered; up/down conflicts are deliberately left to the game logic.
module button_conditioner
  import pong_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic [3:0] btn_n_raw,
  output logic       up_p1,
  output logic       down_p1,
  output logic       up_p2,
  output logic       down_p2,
  output logic [3:0] press_pulse,
  output logic [3:0] release_pulse,
  output logic       any_press
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [3:0] level_n;
  logic [3:0] press_nxt;
  logic       any_press_q, any_press_d;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk_0        (clk_0),
      .rst          (rst),
      .btn_n_raw    (btn_n_raw[i]),
      .level_n      (level_n[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .press_nxt    (press_nxt[i])
    );
  end

  always_comb begin
    any_press_d = |press_nxt;
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= any_press_d;
    end
  end

  assign any_press = any_press_q;
  assign up_p1     = level_n[BTN_UP_P1];
  assign down_p1   = level_n[BTN_DOWN_P1];
  assign up_p2     = level_n[BTN_UP_P2];
  assign down_p2   = level_n[BTN_DOWN_P2];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner at DB_CYCLES=8: expected pulse events queued when stimulus is driven,
// matched against observed pulses at the falling edge.
module tb_button_conditioner;

  localparam int DB  = 8;
  localparam int LAT = DB + 2;

  logic       clk_0 = 1'b0;
  logic       rst   = 1'b0;
  logic [3:0] btn_n_raw = 4'b0000;
  logic       up_p1, down_p1, up_p2, down_p2;
  logic [3:0] press_pulse, release_pulse;
  logic       any_press;
  logic [3:0] lv;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic       any;
    logic [3:0] lv;
  } exp_t;

  exp_t sb[$];

  button_conditioner #(.DB_CYCLES(DB)) dut (
    .clk_0        (clk_0),
    .rst          (rst),
    .btn_n_raw    (btn_n_raw),
    .up_p1        (up_p1),
    .down_p1      (down_p1),
    .up_p2        (up_p2),
    .down_p2      (down_p2),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .any_press    (any_press)
  );

  always #5 clk_0 = ~clk_0;

  assign lv = {down_p2, up_p2, down_p1, up_p1};

  always @(posedge clk_0) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] press, input logic [3:0] rel, input logic [3:0] lvl);
    exp_t e;
    e.cyc   = cyc + LAT;
    e.press = press;
    e.rel   = rel;
    e.any   = |press;
    e.lv    = lvl;
    sb.push_back(e);
  endtask

  // Every pulse must match the oldest pending event; an event whose cycle passes unseen is a miss.
  always @(negedge clk_0) begin
    exp_t e;
    if ((press_pulse | release_pulse) != 4'b0000 || any_press) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {23'd0, any_press, press_pulse, release_pulse}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_cyc", cyc, e.cyc);
        chk("press", {28'd0, press_pulse}, {28'd0, e.press});
        chk("release", {28'd0, release_pulse}, {28'd0, e.rel});
        chk("any_press", {31'd0, any_press}, {31'd0, e.any});
        chk("level", {28'd0, lv}, {28'd0, e.lv});
      end
    end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
      e = sb.pop_front();
      chk("missing_pulse", cyc, e.cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk_0);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running want=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // reset held with all buttons pressed
    idle(4);
    chk("rst_level", {28'd0, lv}, 32'hF);
    chk("rst_press", {28'd0, press_pulse}, 32'h0);
    chk("rst_release", {28'd0, release_pulse}, 32'h0);
    chk("rst_any", {31'd0, any_press}, 32'h0);
    rst = 1'b1;
    push(4'b1111, 4'b0000, 4'b0000);
    wait_drain();
    chk("held_level", {28'd0, lv}, 32'h0);
    btn_n_raw = 4'b1111;
    push(4'b0000, 4'b1111, 4'b1111);
    wait_drain();

    // clean press and release on up_p1
    btn_n_raw = 4'b1110;
    push(4'b0001, 4'b0000, 4'b1110);
    wait_drain();
    btn_n_raw = 4'b1111;
    push(4'b0000, 4'b0001, 4'b1111);
    wait_drain();

    // bounce on down_p1: two 7-cycle lows are both rejected
    btn_n_raw = 4'b1101;
    idle(7);
    btn_n_raw = 4'b1111;
    idle(3);
    btn_n_raw = 4'b1101;
    idle(7);
    btn_n_raw = 4'b1111;
    idle(16);
    chk("bounce_level", {31'd0, down_p1}, 32'h1);

    // up_p2 release with a 5-cycle low glitch
    btn_n_raw = 4'b1011;
    push(4'b0100, 4'b0000, 4'b1011);
    wait_drain();
    btn_n_raw = 4'b1111;
    idle(3);
    btn_n_raw = 4'b1011;
    idle(5);
    btn_n_raw = 4'b1111;
    push(4'b0000, 4'b0100, 4'b1111);
    wait_drain();

    // simultaneous press and release on up_p2/down_p2
    btn_n_raw = 4'b0011;
    push(4'b1100, 4'b0000, 4'b0011);
    wait_drain();
    btn_n_raw = 4'b1111;
    push(4'b0000, 4'b1100, 4'b1111);
    wait_drain();

    // async reset while up_p1 is mid-debounce and down_p2 is held
    btn_n_raw = 4'b0111;
    push(4'b1000, 4'b0000, 4'b0111);
    wait_drain();
    btn_n_raw = 4'b0110;
    idle(7);
    #2 rst = 1'b0;
    #1;
    chk("arst_level", {28'd0, lv}, 32'hF);
    chk("arst_press", {28'd0, press_pulse}, 32'h0);
    chk("arst_any", {31'd0, any_press}, 32'h0);
    idle(2);
    rst = 1'b1;
    push(4'b1001, 4'b0000, 4'b0110);
    wait_drain();
    btn_n_raw = 4'b1111;
    push(4'b0000, 4'b1001, 4'b1111);
    wait_drain();

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the four raw active-low player push-buttons before they reach the game logic. Each button is synchronised into `clk_0`, debounced by a per-channel state machine, and presented as a clean active-low level plus one-cycle press/release pulses. Outputs feed the paddle-control and menu-exit inputs of the game-logic stage directly.

## Interface
- `DB_CYCLES`, 251_750: consecutive stable cycles required to accept a level change (10 ms at 25.175 MHz); legal range 2..2^20-1.
- `CNT_W`, derived as ceil(log2(DB_CYCLES+1)): counter width; not user-set.
- `clk_0`  in  1  25.175 MHz system clock.
- `rst`  in  1  Reset, asynchronous, active-low.
- `btn_n_raw`  in  4  Raw buttons, active-low, asynchronous to `clk_0`. Bit order: [0] up_p1, [1] down_p1, [2] up_p2, [3] down_p2.
- `up_p1`, `down_p1`, `up_p2`, `down_p2`  out  1 each  Debounced levels, active-low (0 = held).
- `press_pulse`  out  4  One-cycle high on an accepted press; same bit order.
- `release_pulse`  out  4  One-cycle high on an accepted release.
- `any_press`  out  1  OR of `press_pulse`, registered with it.

## Operation
- Synchroniser: two flops per bit. Both reset to 1 (released). Second flop output is `s`.
- Per-channel FSM, 2-bit state:
  - RELEASED: level out 1. If `s`=0, go to PRESS_WAIT with `cnt`=1; otherwise hold with `cnt`=0.
  - PRESS_WAIT: if `s`=1, return to RELEASED with `cnt`=0 (bounce rejected). Else if `cnt`=DB_CYCLES-1, go to PRESSED, drive level 0, pulse `press_pulse`, clear `cnt`. Else `cnt`+1.
  - PRESSED: level out 0. If `s`=1, go to RELEASE_WAIT with `cnt`=1.
  - RELEASE_WAIT: mirror of PRESS_WAIT. On `s`=0, return to PRESSED. At `cnt`=DB_CYCLES-1 go to RELEASED, drive level 1, pulse `release_pulse`.
- Channels are fully independent. Simultaneous presses on several bits produce simultaneous pulses, and `any_press` is high once.
- The block never combines up and down. Up+down conflict resolution belongs to the game logic.
- `cnt` cannot overflow: it is cleared or saturates at DB_CYCLES-1 before the transition.
- Reset values: sync flops 1, all states RELEASED, `cnt` 0, level outputs 1, `press_pulse`/`release_pulse`/`any_press` 0.
- Reset mid-debounce: everything returns to the reset values immediately (asynchronous). A button still held after reset deasserts is debounced from scratch and produces a normal press pulse.

## Timing
- All outputs are registered; no combinational path from `btn_n_raw`.
- Latency: raw edge to `s` takes 2 edges. With `s` stable, the level output and pulse change DB_CYCLES edges later, for a total of DB_CYCLES+2 cycles from raw edge to output (±1 cycle from sampling phase).
- Acceptance needs exactly DB_CYCLES consecutive cycles of the new `s` value: the entry cycle plus DB_CYCLES-1 further cycles. A glitch of DB_CYCLES-1 cycles or fewer is always rejected.
- Pulses are exactly 1 cycle wide and coincide with the level output change.
- Minimum interval between a press pulse and the next release pulse on one channel is DB_CYCLES cycles.

## Structure
- Shared package `pong_pkg`:
  - button index constants `BTN_UP_P1`=0, `BTN_DOWN_P1`=1, `BTN_UP_P2`=2, `BTN_DOWN_P2`=3;
  - default `DB_CYCLES`;
  - FSM state encoding RELEASED/PRESS_WAIT/PRESSED/RELEASE_WAIT.
- Sub-module `debounce_channel`: synchroniser, FSM and counter for one bit. The top level instantiates it 4 times and maps the outputs to named ports and `any_press`.

## Test plan
All scenarios run with `DB_CYCLES`=8.
- Reset: hold `rst`=0, drive `btn_n_raw`=4'b0000. Required response: all levels 1, all pulses 0. Release reset with buttons still held: each level goes to 0 and `press_pulse`=4'b1111 for one cycle, 10 cycles after reset release (±1).
- Clean press: drive bit0 low at cycle 0. Required response: `up_p1` goes to 0 at cycle 10 (±1), `press_pulse[0]`=1 for exactly one cycle, `any_press`=1 in the same cycle.
- Bounce rejection: toggle bit1 low for 7 cycles, high for 3, low for 7, then high. Required response: `down_p1` stays 1 and no pulse fires.
- Release: from PRESSED on bit2, drive it high with a 5-cycle low glitch partway. Required response: the counter restarts at the glitch, then `up_p2` goes to 1 eight stable cycles after the final rise, with one `release_pulse[2]`.
- Simultaneous: press bits 2 and 3 in the same cycle. Required response: `up_p2` and `down_p2` both go to 0 in the same cycle, and `any_press` is high for a single cycle.
- Async reset mid-debounce: assert `rst` while bit0 is in PRESS_WAIT with `cnt`=5. Required response: outputs return to reset values without waiting for a clock edge; after release, acceptance takes a full 10 cycles again.
